// File: rtl/kamacore_pkg.sv
// Shared constants and types for the kamacore instruction fetch slice.
package kamacore_pkg;

  // Default datapath/address width and instruction width.
  localparam int unsigned CPU_WIDTH  = 32;
  localparam int unsigned INST_WIDTH = 32;

  // Fetch control state: RUN issues requests, FLUSH drains stale responses.
  typedef enum logic [0:0] {
    StRun,
    StFlush
  } fetch_state_e;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/kamacore_fifo.sv
// Synchronous FIFO with flush; simultaneous push and pop on a full FIFO is allowed.
// Storage is reset to zero so the head reads as zero while in reset.
module kamacore_fifo
  import kamacore_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      empty,
  output logic                      full,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/kamacore_fetch.sv
// Instruction fetch unit: issues sequential PC requests to instruction memory, matches in-order
// responses to their PCs, buffers them and hands them to decode. Redirects reload the PC and
// discard everything in flight.
// Optional build macro KAMACORE_FETCH_BYPASS_EN: forward a response straight to the
// instruction channel when the buffer is empty, saving one cycle of latency.
module kamacore_fetch #(
  parameter int unsigned          CPU_WIDTH  = kamacore_pkg::CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = CPU_WIDTH'(32'h0000_0000),
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [CPU_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [CPU_WIDTH-1:0] imem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [CPU_WIDTH-1:0] inst_data,
  output logic [CPU_WIDTH-1:0] inst_pc
);

  import kamacore_pkg::*;

  localparam int unsigned CW = cnt_w(FIFO_DEPTH);
  localparam int unsigned EW = 2 * CPU_WIDTH;

  fetch_state_e         state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]        out_cnt_q, out_cnt_d;
  logic [CW-1:0]        disc_cnt_q, disc_cnt_d;

  logic                 run;
  logic [CW:0]          inflight;
  logic                 req_valid;
  logic                 req_hs;
  logic                 rsp_live;
  logic [CPU_WIDTH-1:0] rsp_pc;

  logic                 fifo_push, fifo_pop;
  logic                 fifo_empty, fifo_full;
  logic [CW-1:0]        fifo_count;
  logic [EW-1:0]        fifo_wdata, fifo_rdata;
  logic [CPU_WIDTH-1:0] head_data, head_pc;

  logic                 unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], fifo_full};

  assign run       = (state_q == StRun);
  assign inflight  = {1'b0, out_cnt_q} + {1'b0, fifo_count};
  // Gated by rst_n so nothing is requested while reset is held.
  assign req_valid = rst_n && run && (inflight < (CW + 1)'(FIFO_DEPTH));
  assign req_hs    = req_valid && imem_req_ready;

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;

  // A response is kept only in RUN and never in a redirect cycle.
  assign rsp_live = rst_n && imem_rsp_valid && run && !redirect_valid;
  // Live requests since the last redirect are contiguous, so the oldest one sits
  // out_cnt words behind the fetch PC.
  assign rsp_pc   = pc_q - (CPU_WIDTH'(out_cnt_q) << 2);

  assign fifo_wdata = {imem_rsp_data, rsp_pc};
  assign head_data  = fifo_rdata[EW-1:CPU_WIDTH];
  assign head_pc    = fifo_rdata[CPU_WIDTH-1:0];

`ifdef KAMACORE_FETCH_BYPASS_EN
  logic bypass;
  assign bypass     = fifo_empty && rsp_live;
  assign inst_valid = !fifo_empty || bypass;
  assign inst_data  = bypass ? imem_rsp_data : head_data;
  assign inst_pc    = bypass ? rsp_pc : head_pc;
  // A forwarded response that decode takes this cycle never touches the buffer.
  assign fifo_push  = rsp_live && !(bypass && inst_ready);
`else
  assign inst_valid = !fifo_empty;
  assign inst_data  = head_data;
  assign inst_pc    = head_pc;
  assign fifo_push  = rsp_live;
`endif

  assign fifo_pop = inst_valid && inst_ready && !fifo_empty;

  kamacore_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Next PC, counters and state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q;
    disc_cnt_d = disc_cnt_q;

    if (redirect_valid) begin
      pc_d = {redirect_pc[CPU_WIDTH-1:2], 2'b00};
    end else if (req_hs) begin
      pc_d = pc_q + CPU_WIDTH'(4);
    end

    unique case (state_q)
      StRun: begin
        if (redirect_valid) begin
          // Everything in flight, including a request accepted this cycle, becomes a
          // discard; a response landing now is already dropped.
          out_cnt_d  = '0;
          disc_cnt_d = out_cnt_q + CW'(req_hs) - CW'(imem_rsp_valid);
          state_d    = (disc_cnt_d != '0) ? StFlush : StRun;
        end else begin
          out_cnt_d = out_cnt_q + CW'(req_hs) - CW'(imem_rsp_valid);
        end
      end
      StFlush: begin
        // No requests issue here, so a redirect adds no discards.
        disc_cnt_d = disc_cnt_q - CW'(imem_rsp_valid);
        if (disc_cnt_d == '0) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

endmodule

// File: tb/tb_kamacore_fetch.sv
// Self-checking bench for kamacore_fetch: in-order memory model with configurable latency,
// and a reference model of the expected request and instruction PC streams.
module tb_kamacore_fetch;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 2;
`ifdef KAMACORE_FETCH_BYPASS_EN
  localparam int FIRST_INST_CYC = 1;
`else
  localparam int FIRST_INST_CYC = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req_valid, imem_req_ready;
  logic [W-1:0] imem_req_addr;
  logic         imem_rsp_valid;
  logic [W-1:0] imem_rsp_data;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         inst_valid, inst_ready;
  logic [W-1:0] inst_data, inst_pc;

  always #5 clk = ~clk;

  kamacore_fetch #(
    .CPU_WIDTH  (W),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] req_log[$];
  logic [31:0] inst_log[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Stimulus knobs.
  bit fix_ready = 1'b1, fix_inst = 1'b1, rand_ready = 1'b0, rand_inst = 1'b0;
  bit rand_redir = 1'b0, redir_next = 1'b0;
  logic [31:0] redir_tgt = '0;
  int lat_min = 1, lat_max = 1;
  bit arm_d = 1'b0, fired = 1'b0, fired_now = 1'b0;
  int rsp_since_arm = 0;

  // Reference model state.
  logic [31:0] exp_pc = 32'h0, exp_req = 32'h0;
  int n_req = 0, n_inst = 0, first_req_cyc = -1, first_inst_cyc = -1;
  logic [31:0] last_req = '0, last_inst_pc = '0;
  bit prev_stall = 1'b0, prev_redir = 1'b0;
  logic [31:0] prev_addr = '0;

  // Last sampled outputs.
  logic s_rv, s_iv;
  logic [31:0] s_ra, s_ipc, s_idata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample and check on the falling edge, advance the models.
  task automatic tick();
    bit rsp_drv;
    int due;
    fired_now      = 1'b0;
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : fix_ready;
    inst_ready     = rand_inst ? 1'($urandom_range(0, 1)) : fix_inst;
    rsp_drv        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rsp_drv;
    imem_rsp_data  = rsp_drv ? mem_word(mem_q[0].addr) : $urandom();
    redirect_valid = 1'b0;
    redirect_pc    = $urandom();
    if (redir_next) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt;
      redir_next     = 1'b0;
    end else if (arm_d && rsp_drv && rsp_since_arm >= 1) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      inst_ready     = 1'b1;
      arm_d          = 1'b0;
      fired          = 1'b1;
      fired_now      = 1'b1;
    end else if (rand_redir && $urandom_range(0, 39) == 0) begin
      redirect_valid = 1'b1;
    end

    @(negedge clk);
    s_rv = imem_req_valid;  s_ra = imem_req_addr;
    s_iv = inst_valid;      s_ipc = inst_pc;  s_idata = inst_data;

    if (prev_stall && !prev_redir) begin
      chk("req_hold_valid", 32'(s_rv), 32'd1);
      chk("req_hold_addr", s_ra, prev_addr);
    end
    if (fired_now) chk("redir_cycle_inst_valid", 32'(s_iv), 32'd1);
    if (rsp_drv) begin
      void'(mem_q.pop_front());
      rsp_since_arm++;
    end
    if (s_rv && imem_req_ready) begin
      chk("req_addr", s_ra, exp_req);
      req_log.push_back(s_ra);
      if (first_req_cyc < 0) first_req_cyc = cyc;
      last_req = s_ra;
      n_req++;
      exp_req += 32'd4;
      due = cyc + int'($urandom_range(lat_min, lat_max));
      if (mem_q.size() > 0 && due < mem_q[$].due) due = mem_q[$].due;
      mem_q.push_back('{addr: s_ra, due: due});
    end
    if (s_iv && inst_ready) begin
      chk("inst_pc", s_ipc, exp_pc);
      chk("inst_data", s_idata, mem_word(exp_pc));
      inst_log.push_back(s_ipc);
      if (first_inst_cyc < 0) first_inst_cyc = cyc;
      last_inst_pc = s_ipc;
      n_inst++;
      exp_pc += 32'd4;
    end
    if (redirect_valid) begin
      exp_pc  = redirect_pc & 32'hFFFF_FFFC;
      exp_req = redirect_pc & 32'hFFFF_FFFC;
    end
    chk("outstanding_bound", 32'(mem_q.size() <= int'(DEPTH)), 32'd1);
    prev_stall = s_rv && !imem_req_ready;
    prev_addr  = s_ra;
    prev_redir = redirect_valid;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int base, base_i;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset: outputs quiet even with a stray response on the bus.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    rst_n = 1'b1;

    // Straight-line fetch, memory always ready, latency 1.
    repeat (20) tick();
    chk("first_req_cycle", 32'(first_req_cyc), 32'd0);
    chk("req0", req_log[0], 32'h0);
    chk("req1", req_log[1], 32'h4);
    chk("req2", req_log[2], 32'h8);
    chk("first_inst_cycle", 32'(first_inst_cyc), 32'(FIRST_INST_CYC));
    chk("inst0", inst_log[0], 32'h0);
    chk("inst1", inst_log[1], 32'h4);
    chk("inst2", inst_log[2], 32'h8);

    // Decode stalled: only FIFO_DEPTH requests issue, then none until a pop.
    fix_inst = 1'b0;
    redir_tgt = 32'h0000_0200; redir_next = 1'b1;
    tick();
    base = n_req;
    repeat (12) tick();
    chk("stall_req_count", 32'(n_req - base), 32'(DEPTH));
    chk("stall_req_valid", 32'(s_rv), 32'd0);
    fix_inst = 1'b1;
    tick();
    chk("stall_pop_pc", last_inst_pc, 32'h0000_0200);
    fix_inst = 1'b0;
    tick();
    chk("after_pop_req_valid", 32'(s_rv), 32'd1);

    // Redirect to an unaligned target with two requests outstanding.
    fix_inst = 1'b1; lat_min = 5; lat_max = 5;
    for (int i = 0; i < 60 && mem_q.size() != 2; i++) tick();
    chk("two_outstanding", 32'(mem_q.size()), 32'd2);
    redir_tgt = 32'h0000_0103; redir_next = 1'b1;
    tick();
    base = n_req;
    for (int i = 0; i < 60 && n_req == base; i++) tick();
    chk("redir_req_seen", 32'(n_req > base), 32'd1);
    chk("redir_req_addr", last_req, 32'h0000_0100);
    base_i = n_inst;
    for (int i = 0; i < 60 && n_inst == base_i; i++) tick();
    chk("redir_inst_seen", 32'(n_inst > base_i), 32'd1);
    chk("redir_inst_pc", last_inst_pc, 32'h0000_0100);

    // Redirect coinciding with an instruction handshake and a response.
    fix_inst = 1'b0; lat_min = 3; lat_max = 3;
    redir_tgt = 32'h0000_0280; redir_next = 1'b1;
    tick();
    for (int i = 0; i < 60 && last_req != 32'h0000_0280; i++) tick();
    chk("clean_restart", last_req, 32'h0000_0280);
    rsp_since_arm = 0; arm_d = 1'b1; fired = 1'b0;
    for (int i = 0; i < 60 && !fired; i++) tick();
    chk("combo_fired", 32'(fired), 32'd1);
    arm_d = 1'b0;
    tick();
    chk("combo_fifo_empty", 32'(s_iv), 32'd0);
    fix_inst = 1'b1;
    base_i = n_inst;
    for (int i = 0; i < 60 && n_inst == base_i; i++) tick();
    chk("combo_next_pc", last_inst_pc, 32'h0000_0300);

    // Random handshakes, latency 1..5, random redirects, starting near the address wrap.
    rand_ready = 1'b1; rand_inst = 1'b1; lat_min = 1; lat_max = 5;
    redir_tgt = 32'hFFFF_FFF9; redir_next = 1'b1;
    tick();
    rand_redir = 1'b1;
    base_i = n_inst;
    repeat (3000) tick();
    chk("random_progress", 32'(n_inst - base_i > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
